// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: IF (read-only) and MA (read/write) share one bus, one transaction at a time.
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_done,
    output logic              ma_stall,
    output logic              mem_busy,
    input  logic [DATA_W-1:0] mem_to_core_data,
    output logic [ADDR_W-1:0] core_to_mem_addr,
    output logic [DATA_W-1:0] core_to_mem_data,
    output logic              core_to_mem_write_enable
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be in 1..7");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       owner_ma;
    logic       op_write;
    logic [2:0] cnt;
    logic       grant_if;
    logic       grant_ma;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == 3'(STARVE_LIMIT));
    assign grant_if   = (state == IDLE) && if_req && (!ma_req || starve_hit);
    assign grant_ma   = (state == IDLE) && ma_req && !grant_if;

    // Counts MA wins that left IF waiting; any IF win or idle-without-IF cycle forgives.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= 3'd0;
        else if (grant_if || (state == IDLE && !if_req))
            starve_cnt <= 3'd0;
        else if (grant_ma && if_req)
            starve_cnt <= starve_cnt + 3'd1;
    end
`else
    assign grant_ma = (state == IDLE) && ma_req;
    assign grant_if = (state == IDLE) && if_req && !ma_req;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_ma || grant_if) state_next = ACCESS;
            ACCESS:  if (op_write || cnt == 3'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the read-data holding registers are cleared on reset so a dropped read never leaks stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_to_mem_addr         <= '0;
            core_to_mem_data         <= '0;
            core_to_mem_write_enable <= 1'b0;
            if_rdata                 <= '0;
            ma_rdata                 <= '0;
            owner_ma                 <= 1'b0;
            op_write                 <= 1'b0;
            cnt                      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ma || grant_if) begin
                        core_to_mem_addr <= grant_ma ? ma_addr : if_addr;
                        owner_ma         <= grant_ma;
                        op_write         <= grant_ma && ma_we;
                        cnt              <= 3'(MEM_LATENCY);
                        if (grant_ma && ma_we) begin
                            core_to_mem_data         <= ma_wdata;
                            core_to_mem_write_enable <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    core_to_mem_write_enable <= 1'b0;
                    if (!op_write) begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            if (owner_ma)
                                ma_rdata <= mem_to_core_data;
                            else
                                if_rdata <= mem_to_core_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_done  = (state == RESP) && !owner_ma;
    assign ma_done  = (state == RESP) && owner_ma;
    assign if_stall = if_req && !if_done;
    assign ma_stall = ma_req && !ma_done;
    assign mem_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
// A second instance with MEM_LATENCY=3 covers the long-latency path.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int LAT    = 1;
    localparam int LAT3   = 3;
    localparam int LIMIT  = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              if_req, ma_req, ma_we;
    logic [ADDR_W-1:0] if_addr, ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic [DATA_W-1:0] if_rdata, ma_rdata, mem_to_core_data, core_to_mem_data;
    logic              if_done, if_stall, ma_done, ma_stall, mem_busy, core_to_mem_write_enable;
    logic [ADDR_W-1:0] core_to_mem_addr;

    logic              l3_if_req, l3_ma_req, l3_ma_we;
    logic [ADDR_W-1:0] l3_if_addr, l3_ma_addr;
    logic [DATA_W-1:0] l3_ma_wdata;
    logic [DATA_W-1:0] l3_if_rdata, l3_ma_rdata, l3_mem_data, l3_wdata_out;
    logic              l3_if_done, l3_if_stall, l3_ma_done, l3_ma_stall, l3_busy, l3_we_out;
    logic [ADDR_W-1:0] l3_addr_out;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata), .ma_done(ma_done), .ma_stall(ma_stall), .mem_busy(mem_busy),
        .mem_to_core_data(mem_to_core_data), .core_to_mem_addr(core_to_mem_addr),
        .core_to_mem_data(core_to_mem_data), .core_to_mem_write_enable(core_to_mem_write_enable)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT3), .STARVE_LIMIT(LIMIT)) dut_l3 (
        .clk(clk), .reset(reset),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_rdata(l3_if_rdata), .if_done(l3_if_done),
        .if_stall(l3_if_stall),
        .ma_req(l3_ma_req), .ma_we(l3_ma_we), .ma_addr(l3_ma_addr), .ma_wdata(l3_ma_wdata),
        .ma_rdata(l3_ma_rdata), .ma_done(l3_ma_done), .ma_stall(l3_ma_stall), .mem_busy(l3_busy),
        .mem_to_core_data(l3_mem_data), .core_to_mem_addr(l3_addr_out),
        .core_to_mem_data(l3_wdata_out), .core_to_mem_write_enable(l3_we_out)
    );

    // Memory contents: one fixed word for the read-timing test, a simple scramble elsewhere.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 24'h000010) return 16'hBEEF;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Memory returns valid data only in the L-th cycle of a transaction; garbage otherwise.
    int age = 0;
    int age3 = 0;
    always @(posedge clk) age  <= mem_busy ? age + 1 : 0;
    always @(posedge clk) age3 <= l3_busy ? age3 + 1 : 0;
    assign mem_to_core_data = (age == LAT - 1)   ? mem_word(core_to_mem_addr) : 16'hDEAD;
    assign l3_mem_data      = (age3 == LAT3 - 1) ? mem_word(l3_addr_out)      : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant at cycle g finishes at g+2 (write) or g+LAT+1 (read).
    int              n = 0;
    int              grant_cyc = 0;
    int              done_at = 0;
    bit              m_owner_ma = 1'b0;
    bit              m_write = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [DATA_W-1:0] m_if_rdata = '0;
    logic [DATA_W-1:0] m_ma_rdata = '0;
    int              m_starve = 0;

    initial begin
        bit busy, e_if_done, e_ma_done, e_we, pick_if, pick_ma;
        forever begin
            @(negedge clk);
            busy      = (grant_cyc < n) && (n <= done_at);
            e_if_done = busy && (n == done_at) && !m_owner_ma;
            e_ma_done = busy && (n == done_at) && m_owner_ma;
            e_we      = busy && m_write && (n == grant_cyc + 1);
            check("m_mem_busy", mem_busy, busy);
            check("m_if_done", if_done, e_if_done);
            check("m_ma_done", ma_done, e_ma_done);
            check("m_if_stall", if_stall, if_req & ~e_if_done);
            check("m_ma_stall", ma_stall, ma_req & ~e_ma_done);
            check("m_we", core_to_mem_write_enable, e_we);
            check("m_addr", core_to_mem_addr, m_addr);
            check("m_wdata", core_to_mem_data, m_data);
            check("m_if_rdata", if_rdata, m_if_rdata);
            check("m_ma_rdata", ma_rdata, m_ma_rdata);

            if (reset) begin
                grant_cyc = n; done_at = n; m_write = 1'b0;
                m_addr = '0; m_data = '0; m_if_rdata = '0; m_ma_rdata = '0; m_starve = 0;
            end else if (n > done_at) begin
                pick_if = if_req && (!ma_req || (GUARD && m_starve == LIMIT));
                pick_ma = ma_req && !pick_if;
                if (pick_if || !if_req) m_starve = 0;
                else if (pick_ma) m_starve++;
                if (pick_if || pick_ma) begin
                    grant_cyc  = n;
                    m_owner_ma = pick_ma;
                    m_write    = pick_ma && ma_we;
                    m_addr     = pick_ma ? ma_addr : if_addr;
                    if (m_write) m_data = ma_wdata;
                    done_at    = n + (m_write ? 2 : LAT + 1);
                end
            end else if (!m_write && n == done_at - 1) begin
                if (m_owner_ma) m_ma_rdata = mem_word(m_addr);
                else            m_if_rdata = mem_word(m_addr);
            end
            n++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ma_at, if_at, ma_cnt, ma_at_if;
        bit stall_ok, seen;

        if_req = 0; if_addr = '0; ma_req = 0; ma_we = 0; ma_addr = '0; ma_wdata = '0;
        l3_if_req = 0; l3_if_addr = '0; l3_ma_req = 0; l3_ma_we = 0; l3_ma_addr = '0; l3_ma_wdata = '0;

        tick; tick;
        check("rst_busy", mem_busy, 0);
        check("rst_addr", core_to_mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        reset = 0;
        tick;

        // Read timing, latency 1
        if_addr = 24'h000010; if_req = 1;
        tick;
        check("rd_addr_t1", core_to_mem_addr, 24'h000010);
        check("rd_busy_t1", mem_busy, 1);
        check("rd_done_t1", if_done, 0);
        tick;
        check("rd_done_t2", if_done, 1);
        check("rd_data_t2", if_rdata, 16'hBEEF);
        if_req = 0;
        tick;
        check("rd_idle_t3", mem_busy, 0);

        // MA read to give ma_rdata a known value
        ma_addr = 24'h000033; ma_we = 0; ma_req = 1;
        tick; tick;
        check("mard_done", ma_done, 1);
        check("mard_data", ma_rdata, 16'hA5F0);
        ma_req = 0;
        tick;

        // Write timing; address/data changes after the grant must be ignored
        ma_addr = 24'h000200; ma_wdata = 16'h1234; ma_we = 1; ma_req = 1;
        tick;
        check("wr_we_t1", core_to_mem_write_enable, 1);
        check("wr_addr_t1", core_to_mem_addr, 24'h000200);
        check("wr_data_t1", core_to_mem_data, 16'h1234);
        ma_addr = 24'h000999; ma_wdata = 16'hFFFF;
        tick;
        check("wr_we_t2", core_to_mem_write_enable, 0);
        check("wr_done_t2", ma_done, 1);
        check("wr_rdata_kept", ma_rdata, 16'hA5F0);
        check("wr_addr_held", core_to_mem_addr, 24'h000200);
        ma_req = 0; ma_we = 0;
        tick;
        check("wr_data_held", core_to_mem_data, 16'h1234);

        // Simultaneous requests: MA first, IF on the IDLE cycle after MA's RESP
        if_addr = 24'h000044; ma_addr = 24'h000055; ma_req = 1; if_req = 1;
        ma_at = -1; if_at = -1; stall_ok = 1;
        for (int i = 1; i <= 20 && if_at < 0; i++) begin
            tick;
            if (ma_done) begin ma_at = i; ma_req = 0; end
            if (if_done) begin if_at = i; if_req = 0; end
            else if (!if_stall) stall_ok = 0;
        end
        check("sim_ma_at", ma_at, 2);
        check("sim_if_at", if_at, 5);
        check("sim_if_stall", stall_ok, 1);
        check("sim_ma_rdata", ma_rdata, 16'hA596);
        check("sim_if_rdata", if_rdata, 16'hA587);
        tick;

        // Reset during ACCESS, then the reissued request completes
        if_addr = 24'h000066; if_req = 1;
        tick;
        check("rstm_busy_pre", mem_busy, 1);
        reset = 1;
        tick;
        check("rstm_done", if_done, 0);
        check("rstm_busy", mem_busy, 0);
        check("rstm_addr", core_to_mem_addr, 0);
        check("rstm_if_rdata", if_rdata, 0);
        check("rstm_ma_rdata", ma_rdata, 0);
        check("rstm_wdata", core_to_mem_data, 0);
        reset = 0;
        if_at = -1;
        for (int i = 1; i <= 10 && if_at < 0; i++) begin
            tick;
            if (if_done) begin if_at = i; if_req = 0; end
        end
        check("rstm_reissue_at", if_at, 2);
        check("rstm_reissue_data", if_rdata, 16'hA5A5);
        tick;

        // Starvation: MA keeps requesting while IF waits
        ma_addr = 24'h000070; ma_we = 0; if_addr = 24'h000080; ma_req = 1; if_req = 1;
        ma_cnt = 0; if_at = -1; ma_at_if = -1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (ma_done) ma_cnt++;
            if (if_done && if_at < 0) begin if_at = i; ma_at_if = ma_cnt; end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_ma_before_if", ma_at_if, 4);
        check("starve_if_at", if_at, 14);
`else
        check("nostarve_if_at", if_at, -1);
        check("nostarve_ma_cnt", ma_cnt, 13);
`endif
        ma_req = 0;
        seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick;
            if (if_done) begin seen = 1; if_req = 0; end
        end
        check("starve_if_finishes", seen, 1);
        tick; tick;

        // Long latency on the MEM_LATENCY=3 instance
        l3_if_addr = 24'h000077; l3_if_req = 1;
        tick;
        check("l3_addr_t1", l3_addr_out, 24'h000077);
        check("l3_busy_t1", l3_busy, 1);
        tick;
        check("l3_addr_t2", l3_addr_out, 24'h000077);
        check("l3_done_t2", l3_if_done, 0);
        tick;
        check("l3_addr_t3", l3_addr_out, 24'h000077);
        check("l3_done_t3", l3_if_done, 0);
        check("l3_rdata_t3", l3_if_rdata, 0);
        tick;
        check("l3_done_t4", l3_if_done, 1);
        check("l3_rdata_t4", l3_if_rdata, 16'hA5B4);
        l3_if_req = 0;
        tick;
        check("l3_idle_t5", l3_busy, 0);
        check("l3_done_t5", l3_if_done, 0);

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch stage (read-only) and the memory-access stage (read/write).
- One transaction is outstanding at a time.
- Sits between the pipeline stages and the external memory bus, and drives core_to_mem_addr, core_to_mem_data and core_to_mem_write_enable.
- Per-requester done pulses tell the pipeline when to advance; stall outputs freeze it otherwise.

Parameters:
- ADDR_W, 24, memory address width.
- DATA_W, 16, memory data width.
- MEM_LATENCY, 1, cycles from address presented to read data valid on mem_to_core_data; legal range 1..7.
- STARVE_LIMIT, 4, consecutive MA grants allowed while IF waits; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  IF read request; held high until if_done.
- if_addr  input  ADDR_W  IF fetch address.
- if_rdata  output  DATA_W  last instruction word read for IF.
- if_done  output  1  one-cycle completion pulse for IF.
- if_stall  output  1  if_req & ~if_done.
- ma_req  input  1  MA request; held high until ma_done.
- ma_we  input  1  1 = write, 0 = read.
- ma_addr  input  ADDR_W  MA address.
- ma_wdata  input  DATA_W  MA write data.
- ma_rdata  output  DATA_W  last data word read for MA.
- ma_done  output  1  one-cycle completion pulse for MA.
- ma_stall  output  1  ma_req & ~ma_done.
- mem_busy  output  1  high whenever state != IDLE.
- mem_to_core_data  input  DATA_W  memory read data.
- core_to_mem_addr  output  ADDR_W  registered memory address.
- core_to_mem_data  output  DATA_W  registered memory write data.
- core_to_mem_write_enable  output  1  registered write strobe.

Behaviour:
- Reset values: all outputs 0; state IDLE; latency counter 0; starvation counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests each cycle.
  - If ma_req is high, MA wins; else if if_req is high, IF wins; else stay in IDLE.
  - On a grant at the edge ending cycle T, register the winner's address into core_to_mem_addr.
  - For an MA write, also register ma_wdata into core_to_mem_data and set core_to_mem_write_enable=1.
  - Latch the owner and the operation; set cnt=MEM_LATENCY; go to ACCESS.
- ACCESS:
  - core_to_mem_write_enable is high for exactly the first ACCESS cycle, and only for writes.
  - Write: at the end of the first ACCESS cycle, go to RESP.
  - Read: decrement cnt each cycle. At the edge where cnt==1, capture mem_to_core_data into the owner's rdata register, then go to RESP.
- RESP:
  - The owner's done is high for exactly this one cycle; both requests are ignored.
  - Next edge: return to IDLE.
  - A requester that still holds req in IDLE is treated as issuing a new request.
- Latency, request sampled at cycle T:
  - Read: address valid cycles T+1..T+MEM_LATENCY; done at T+MEM_LATENCY+1.
  - Write: strobe at T+1; done at T+2.
- Between transactions, core_to_mem_addr and core_to_mem_data hold their last values; core_to_mem_write_enable is 0 outside the first write ACCESS cycle.
- ma_rdata changes only on MA read completion; a write leaves it unchanged. if_rdata changes only on IF read completion.
- Request inputs are sampled only in IDLE. Changes to addr/data/we after the grant are ignored.
- Reset mid-transaction: return to IDLE; done, write enable and mem_busy go low next cycle; the transaction is dropped and the requester must reissue it. rdata registers are cleared to 0.
- if_done and ma_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit counter increments on each MA grant issued while if_req is high.
  - It clears on any IF grant, or on any IDLE cycle with if_req low.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants IF even if ma_req is high.
- When undefined: strict MA priority and no counter logic.

Test Plan:
- Read timing: MEM_LATENCY=1; if_req with if_addr=0x000010; memory returns 0xBEEF at address 0x10 one cycle after the address. Required: core_to_mem_addr=0x000010 at T+1; if_done high and if_rdata=0xBEEF at T+2; mem_busy low at T+3.
- Write timing: ma_req, ma_we=1, ma_addr=0x000200, ma_wdata=0x1234. Required: write enable high only in cycle T+1, with addr 0x000200 and data 0x1234; ma_done at T+2; ma_rdata unchanged.
- Simultaneous requests: if_req and ma_req both high in one cycle. Required: MA is served first, ma_done precedes if_done, IF is granted on the IDLE cycle after MA's RESP; if_stall stays high throughout.
- Long latency: MEM_LATENCY=3, IF read. Required: done at T+4 with data captured at the edge ending cycle T+3; address held T+1..T+3.
- Reset mid-operation: assert reset during ACCESS. Required: next cycle all outputs 0, state IDLE, no done pulse; a reissued request completes normally.
- Starvation guard: MEM_ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=4, ma_req continuously re-asserted and if_req high. Required: IF granted after exactly 4 MA transactions. With the macro undefined, IF is never granted while ma_req stays high.
